traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameters SHALL be, one per line as name, default, meaning:
- GREEN_T, 30, green phase length in clk cycles.
- YELLOW_T, 3, yellow phase length.
- ALLRED_T, 2, all-red clearance length.
- PED_MIN_T, 10, minimum green before a pedestrian request may shorten it.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, clock; one cycle is one time unit (1 s in system use).
- reset, in, 1, synchronous active-high reset.
- hold, in, 1, freeze the phase timer and state while high.
- ped_req, in, 1, pedestrian button; level or pulse.
- ns_light, out, 3, north-south lamps {red,yellow,green}, one-hot.
- ew_light, out, 3, east-west lamps {red,yellow,green}, one-hot.
- cnt, out, 6, elapsed cycles in the current phase.
- over_flag, out, 1, high in the final cycle of the current phase.
- ped_walk, out, 1, pedestrian walk lamp.

Function
REQ-004 The FSM SHALL have six states in a fixed cycle: NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2 -> NS_GREEN.
REQ-005 Phase lengths SHALL be GREEN_T for both greens, YELLOW_T for both yellows and ALLRED_T for both all-reds.
REQ-006 cnt SHALL increment by 1 per cycle. When over_flag=1 and hold=0, cnt SHALL return to 0 and the state SHALL advance on the next edge, so each phase lasts exactly its length in cycles.
REQ-007 over_flag SHALL be decoded from registered state and cnt: it is high when cnt == phase_length-1, or when the shortening condition of REQ-013 holds. It is valid in the same cycle as cnt.
REQ-008 Lamp decode SHALL be as follows; the non-green road always shows red (3'b100), and both roads are never green or yellow together.
- NS_GREEN: ns=001, ew=100.
- NS_YELLOW: ns=010, ew=100.
- ALL_RED_x: both 100.
- EW_GREEN: ns=100, ew=001.
- EW_YELLOW: ns=100, ew=010.
REQ-009 While hold=1, cnt and the state SHALL be frozen, over_flag SHALL still reflect the decode, and the state SHALL NOT advance even if over_flag=1.
REQ-010 cnt SHALL never exceed 62. Parameter values outside 1..63 are illegal; PED_MIN_T SHALL satisfy 1 <= PED_MIN_T <= GREEN_T.
REQ-011 With default parameters the cycle period SHALL be 70 cycles.

Reset
REQ-012 reset=1 SHALL dominate hold and ped_req. On the next edge it SHALL set state=NS_GREEN, cnt=0, ns_light=001, ew_light=100, over_flag=0, ped_walk=0, and clear the pedestrian pending flag. Reset asserted mid-phase SHALL abort that phase without passing through yellow.

Configuration
REQ-013 When macro PED_REQ_EN is defined:
- ped_req=1 in any cycle SHALL set ped_pend on the next edge.
- In either green state, with ped_pend=1 and cnt >= PED_MIN_T-1, over_flag SHALL be high, shortening the green.
- On entry to ALL_RED_1 or ALL_RED_2 with ped_pend=1, ped_walk SHALL go high for that whole all-red phase and ped_pend SHALL clear on that entry edge.
- A ped_req in the same cycle as that clearing edge SHALL re-set ped_pend (the set wins).
REQ-014 When PED_REQ_EN is undefined, the ped_req port SHALL exist but be ignored, ped_walk SHALL be constant 0, and green lengths SHALL always be GREEN_T.

Verification
REQ-015 The bench SHALL cover these scenarios, using default parameters and counting cycles from reset release (cycle 0):
- Free run: over_flag at cycles 29, 32, 34, 64, 67 and 69. NS_YELLOW at 30, ALL_RED_1 at 33, EW_GREEN at 35, EW_YELLOW at 65, ALL_RED_2 at 68, NS_GREEN again at 70 with cnt=0.
- Hold: hold=1 during cycles 10..19 -> cnt stays 10 and NS_GREEN persists; NS_YELLOW starts at cycle 40.
- Reset mid-phase: reset at cycle 66 (EW_YELLOW) -> next cycle NS_GREEN, cnt=0, ew=100, no all-red phase.
- PED_REQ_EN, early press: ped_req pulse at cycle 5 -> over_flag at 9, NS_YELLOW at 10, ALL_RED_1 at 13..14 with ped_walk=1, EW_GREEN at 15.
- PED_REQ_EN, late press: ped_req at cycle 20 -> over_flag at 21, NS_YELLOW at 22.
- Without PED_REQ_EN: the same stimulus as the early-press scenario -> timing identical to free run, and ped_walk=0 throughout.
- Invariant checked every cycle: never both roads non-red.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Six-phase two-road traffic light controller with a per-phase cycle counter.
// Optional pedestrian green-shortening and walk lamp are enabled by defining PED_REQ_EN.
module traffic_light_ctrl #(
  parameter int unsigned GREEN_T   = 30,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned PED_MIN_T = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [5:0] cnt,
  output logic       over_flag,
  output logic       ped_walk
);

  localparam logic [5:0] GreenLast  = 6'(GREEN_T - 1);
  localparam logic [5:0] YellowLast = 6'(YELLOW_T - 1);
  localparam logic [5:0] AllRedLast = 6'(ALLRED_T - 1);
  localparam logic [5:0] PedMinLast = 6'(PED_MIN_T - 1);

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  typedef enum logic [2:0] {
    StNsGreen,
    StNsYellow,
    StAllRed1,
    StEwGreen,
    StEwYellow,
    StAllRed2
  } state_e;

  state_e     r_state, w_state_next;
  logic [5:0] r_cnt, w_cnt_next;
  logic [5:0] w_last;
  logic       w_is_green;
  logic       w_short;
  logic       w_advance;

  always_comb begin
    w_last     = GreenLast;
    w_is_green = 1'b0;
    case (r_state)
      StNsGreen, StEwGreen: begin
        w_last     = GreenLast;
        w_is_green = 1'b1;
      end
      StNsYellow, StEwYellow: w_last = YellowLast;
      StAllRed1, StAllRed2:   w_last = AllRedLast;
      default:                w_last = GreenLast;
    endcase
  end

  assign over_flag = (r_cnt == w_last) || w_short;
  assign w_advance = over_flag && !hold;
  assign cnt       = r_cnt;

  always_comb begin
    w_state_next = r_state;
    if (w_advance) begin
      case (r_state)
        StNsGreen:  w_state_next = StNsYellow;
        StNsYellow: w_state_next = StAllRed1;
        StAllRed1:  w_state_next = StEwGreen;
        StEwGreen:  w_state_next = StEwYellow;
        StEwYellow: w_state_next = StAllRed2;
        StAllRed2:  w_state_next = StNsGreen;
        default:    w_state_next = StNsGreen;
      endcase
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_advance) begin
      w_cnt_next = 6'd0;
    end else if (!hold) begin
      w_cnt_next = r_cnt + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StNsGreen;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    ns_light = LampRed;
    ew_light = LampRed;
    case (r_state)
      StNsGreen:  ns_light = LampGreen;
      StNsYellow: ns_light = LampYellow;
      StEwGreen:  ew_light = LampGreen;
      StEwYellow: ew_light = LampYellow;
      default: begin
        ns_light = LampRed;
        ew_light = LampRed;
      end
    endcase
  end

`ifdef PED_REQ_EN
  logic r_ped_pend;
  logic r_walk;
  logic w_enter_allred;
  logic w_leave_allred;

  assign w_short = w_is_green && r_ped_pend && (r_cnt >= PedMinLast);
  assign w_enter_allred = w_advance &&
                          ((w_state_next == StAllRed1) || (w_state_next == StAllRed2));
  assign w_leave_allred = w_advance && ((r_state == StAllRed1) || (r_state == StAllRed2));

  // A request arriving on the clearing edge re-arms the pending flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ped_pend <= 1'b0;
      r_walk     <= 1'b0;
    end else begin
      r_ped_pend <= ped_req | (r_ped_pend & ~w_enter_allred);
      if (w_enter_allred) begin
        r_walk <= r_ped_pend;
      end else if (w_leave_allred) begin
        r_walk <= 1'b0;
      end
    end
  end

  assign ped_walk = r_walk;
`else
  logic w_unused_ped;
  logic w_unused_green;

  assign w_unused_ped   = ped_req;
  assign w_unused_green = w_is_green;
  assign w_short        = 1'b0;
  assign ped_walk       = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed, table-driven bench for traffic_light_ctrl with default parameters.
// Expectations follow the PED_REQ_EN setting of the build.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       reset;
  logic       hold;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [5:0] cnt;
  logic       over_flag;
  logic       ped_walk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [5:0] cnt;
    logic       over;
    logic       walk;
  } vec_t;

  vec_t tbl[$];

  traffic_light_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .cnt      (cnt),
    .over_flag(over_flag),
    .ped_walk (ped_walk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int c, input logic [2:0] n, input logic [2:0] e,
                              input int k, input logic o, input logic w);
    vec_t v;
    v.cyc  = c;
    v.ns   = n;
    v.ew   = e;
    v.cnt  = 6'(k);
    v.over = o;
    v.walk = w;
    return v;
  endfunction

  task automatic check(input string name, input vec_t v);
    logic [13:0] act;
    logic [13:0] exp;
    act = {ns_light, ew_light, cnt, over_flag, ped_walk};
    exp = {v.ns, v.ew, v.cnt, v.over, v.walk};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got ns=%b ew=%b cnt=%0d over=%b walk=%b want ns=%b ew=%b cnt=%0d over=%b walk=%b",
               name, cyc, ns_light, ew_light, cnt, over_flag, ped_walk,
               v.ns, v.ew, v.cnt, v.over, v.walk);
    end
  endtask

  task automatic apply(input int ped_cyc, input int hold_lo, input int hold_hi,
                       input int rst_cyc);
    ped_req = (cyc == ped_cyc);
    hold    = (cyc >= hold_lo) && (cyc <= hold_hi);
    reset   = (cyc == rst_cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if (ns_light != 3'b100 && ew_light != 3'b100) begin
      failures++;
      $display("FAIL both_non_red cyc=%0d got ns=%b ew=%b want one road red",
               cyc, ns_light, ew_light);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    hold    = 1'b1;
    ped_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    hold    = 1'b0;
    ped_req = 1'b0;
    cyc     = 0;
  endtask

  task automatic run(input string name, input int ped_cyc, input int hold_lo,
                     input int hold_hi, input int rst_cyc);
    do_reset();
    apply(ped_cyc, hold_lo, hold_hi, rst_cyc);
    for (int i = 0; i < tbl.size(); i++) begin
      while (cyc < tbl[i].cyc) begin
        step();
        apply(ped_cyc, hold_lo, hold_hi, rst_cyc);
      end
      check(name, tbl[i]);
    end
    reset   = 1'b0;
    hold    = 1'b0;
    ped_req = 1'b0;
  endtask

  task automatic fill_free();
    tbl.delete();
    tbl.push_back(mk(0,  3'b001, 3'b100, 0,  1'b0, 1'b0));
    tbl.push_back(mk(28, 3'b001, 3'b100, 28, 1'b0, 1'b0));
    tbl.push_back(mk(29, 3'b001, 3'b100, 29, 1'b1, 1'b0));
    tbl.push_back(mk(30, 3'b010, 3'b100, 0,  1'b0, 1'b0));
    tbl.push_back(mk(32, 3'b010, 3'b100, 2,  1'b1, 1'b0));
    tbl.push_back(mk(33, 3'b100, 3'b100, 0,  1'b0, 1'b0));
    tbl.push_back(mk(34, 3'b100, 3'b100, 1,  1'b1, 1'b0));
    tbl.push_back(mk(35, 3'b100, 3'b001, 0,  1'b0, 1'b0));
    tbl.push_back(mk(64, 3'b100, 3'b001, 29, 1'b1, 1'b0));
    tbl.push_back(mk(65, 3'b100, 3'b010, 0,  1'b0, 1'b0));
    tbl.push_back(mk(67, 3'b100, 3'b010, 2,  1'b1, 1'b0));
    tbl.push_back(mk(68, 3'b100, 3'b100, 0,  1'b0, 1'b0));
    tbl.push_back(mk(69, 3'b100, 3'b100, 1,  1'b1, 1'b0));
    tbl.push_back(mk(70, 3'b001, 3'b100, 0,  1'b0, 1'b0));
  endtask

  initial begin
    reset   = 1'b1;
    hold    = 1'b0;
    ped_req = 1'b0;

    fill_free();
    run("free_run", -1, -1, -1, -1);

    tbl.delete();
    tbl.push_back(mk(10, 3'b001, 3'b100, 10, 1'b0, 1'b0));
    tbl.push_back(mk(15, 3'b001, 3'b100, 10, 1'b0, 1'b0));
    tbl.push_back(mk(19, 3'b001, 3'b100, 10, 1'b0, 1'b0));
    tbl.push_back(mk(20, 3'b001, 3'b100, 10, 1'b0, 1'b0));
    tbl.push_back(mk(21, 3'b001, 3'b100, 11, 1'b0, 1'b0));
    tbl.push_back(mk(39, 3'b001, 3'b100, 29, 1'b1, 1'b0));
    tbl.push_back(mk(40, 3'b010, 3'b100, 0,  1'b0, 1'b0));
    run("hold", -1, 10, 19, -1);

    // Hold while over_flag is high must not advance the phase.
    tbl.delete();
    tbl.push_back(mk(29, 3'b001, 3'b100, 29, 1'b1, 1'b0));
    tbl.push_back(mk(32, 3'b001, 3'b100, 29, 1'b1, 1'b0));
    tbl.push_back(mk(33, 3'b010, 3'b100, 0,  1'b0, 1'b0));
    run("hold_at_end", -1, 29, 31, -1);

    tbl.delete();
    tbl.push_back(mk(66, 3'b100, 3'b010, 1,  1'b0, 1'b0));
    tbl.push_back(mk(67, 3'b001, 3'b100, 0,  1'b0, 1'b0));
    tbl.push_back(mk(68, 3'b001, 3'b100, 1,  1'b0, 1'b0));
    tbl.push_back(mk(96, 3'b001, 3'b100, 29, 1'b1, 1'b0));
    tbl.push_back(mk(97, 3'b010, 3'b100, 0,  1'b0, 1'b0));
    run("reset_mid", -1, -1, -1, 66);

`ifdef PED_REQ_EN
    tbl.delete();
    tbl.push_back(mk(8,  3'b001, 3'b100, 8,  1'b0, 1'b0));
    tbl.push_back(mk(9,  3'b001, 3'b100, 9,  1'b1, 1'b0));
    tbl.push_back(mk(10, 3'b010, 3'b100, 0,  1'b0, 1'b0));
    tbl.push_back(mk(12, 3'b010, 3'b100, 2,  1'b1, 1'b0));
    tbl.push_back(mk(13, 3'b100, 3'b100, 0,  1'b0, 1'b1));
    tbl.push_back(mk(14, 3'b100, 3'b100, 1,  1'b1, 1'b1));
    tbl.push_back(mk(15, 3'b100, 3'b001, 0,  1'b0, 1'b0));
    tbl.push_back(mk(44, 3'b100, 3'b001, 29, 1'b1, 1'b0));
    tbl.push_back(mk(45, 3'b100, 3'b010, 0,  1'b0, 1'b0));
    run("ped_early", 5, -1, -1, -1);

    tbl.delete();
    tbl.push_back(mk(20, 3'b001, 3'b100, 20, 1'b0, 1'b0));
    tbl.push_back(mk(21, 3'b001, 3'b100, 21, 1'b1, 1'b0));
    tbl.push_back(mk(22, 3'b010, 3'b100, 0,  1'b0, 1'b0));
    tbl.push_back(mk(25, 3'b100, 3'b100, 0,  1'b0, 1'b1));
    tbl.push_back(mk(27, 3'b100, 3'b001, 0,  1'b0, 1'b0));
    run("ped_late", 20, -1, -1, -1);
`else
    fill_free();
    run("ped_ignored", 5, -1, -1, -1);

    tbl.delete();
    tbl.push_back(mk(21, 3'b001, 3'b100, 21, 1'b0, 1'b0));
    tbl.push_back(mk(22, 3'b001, 3'b100, 22, 1'b0, 1'b0));
    tbl.push_back(mk(30, 3'b010, 3'b100, 0,  1'b0, 1'b0));
    run("ped_late_ignored", 20, -1, -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got no finish want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
